// File: rtl/scmp_microcode_pak.sv
// Shared microcode definitions for the SC/MP datapath.
// Holds the ALU operation codes plus the effective-address sequencer's
// mode/state enums and the displacement value that selects the E register.
package scmp_microcode_pak;

    // ALU operation codes; NUL must stay at zero so an idle requester drives all-zero.
    typedef enum logic [3:0] {
        ALU_OP_NUL = 4'd0,
        ALU_OP_ADD = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_OR  = 4'd3,
        ALU_OP_XOR = 4'd4,
        ALU_OP_SR  = 4'd5,
        ALU_OP_RR  = 4'd6
    } ALU_OP_t;

    // Indexed addressing leaves the pointer alone; auto-indexed writes it back.
    typedef enum logic {
        EA_MODE_IDX  = 1'b0,
        EA_MODE_AUTO = 1'b1
    } EA_MODE_t;

    // Effective-address sequencer states: low byte add, high byte add, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } EA_STATE_t;

    // A displacement of -128 means "use the E register as the displacement".
    localparam logic [7:0] EA_DISP_USE_E = 8'h80;

endpackage

// File: rtl/scmp_ea_seq.sv
// SC/MP effective-address sequencer.
// Borrows the shared 8-bit ALU for two cycles to form ptr + signed displacement
// with 4K page wrap, substituting E for a displacement of 0x80.
// Optional feature: define SCMP_EA_AUTOIDX_EN to enable auto-indexed
// (pre-decrement / post-increment) pointer write-back; without it every
// request is treated as plain indexed and the write-back outputs are tied to 0.
module scmp_ea_seq
    import scmp_microcode_pak::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  EA_MODE_t    mode_i,
    input  logic [15:0] ptr_i,
    input  logic [7:0]  disp_i,
    input  logic [7:0]  e_i,
    output ALU_OP_t     alu_op_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic        alu_cy_o,
    output logic        alu_hcy_sup_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_cy_i,
    output logic        done_o,
    output logic [15:0] ea_o,
    output logic [15:0] ptr_wb_o,
    output logic        ptr_wb_en_o
);

    EA_STATE_t   state_q;
    EA_STATE_t   state_d;
    logic [15:0] ptr_q;
    logic [7:0]  disp_q;
    logic [7:0]  lo_q;
    logic        c_q;
    logic [15:0] ea_q;
    logic [15:0] sum;

    // The page nibble is carried straight through so the address wraps within 4K.
    assign sum = {ptr_q[15:12], alu_res_i[3:0], lo_q};

`ifdef SCMP_EA_AUTOIDX_EN
    EA_MODE_t    mode_q;
    logic [15:0] wb_q;
`else
    logic        unused_mode;
    assign unused_mode = ^mode_i;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed four-cycle walk once a request is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: drive the ALU operands for the current byte and the handshake.
    always_comb begin
        req_ready_o   = 1'b0;
        done_o        = 1'b0;
        alu_op_o      = ALU_OP_NUL;
        alu_a_o       = 8'h00;
        alu_b_o       = 8'h00;
        alu_cy_o      = 1'b0;
        alu_hcy_sup_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
            end
            LO: begin
                alu_op_o = ALU_OP_ADD;
                alu_a_o  = ptr_q[7:0];
                alu_b_o  = disp_q;
            end
            HI: begin
                alu_op_o = ALU_OP_ADD;
                alu_a_o  = ptr_q[15:8];
                alu_b_o  = {8{disp_q[7]}};
                alu_cy_o = c_q;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    // Request capture, with E substituted for the 0x80 displacement (no recursion).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 16'h0000;
            disp_q <= 8'h00;
        end else if (state_q == IDLE && req_valid_i) begin
            ptr_q  <= ptr_i;
            disp_q <= (disp_i == EA_DISP_USE_E) ? e_i : disp_i;
        end
    end

`ifdef SCMP_EA_AUTOIDX_EN
    // Mode is only kept when auto-indexing exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= EA_MODE_IDX;
        end else if (state_q == IDLE && req_valid_i) begin
            mode_q <= mode_i;
        end
    end
`endif

    // Low byte result and carry into the high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= 8'h00;
            c_q  <= 1'b0;
        end else if (state_q == LO) begin
            lo_q <= alu_res_i;
            c_q  <= alu_cy_i;
        end
    end

    // Result registers load at the end of HI and hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_q <= 16'h0000;
`ifdef SCMP_EA_AUTOIDX_EN
            wb_q <= 16'h0000;
`endif
        end else if (state_q == HI) begin
`ifdef SCMP_EA_AUTOIDX_EN
            wb_q <= sum;
            if (mode_q == EA_MODE_AUTO && !disp_q[7]) begin
                ea_q <= ptr_q;
            end else begin
                ea_q <= sum;
            end
`else
            ea_q <= sum;
`endif
        end
    end

    assign ea_o = ea_q;

`ifdef SCMP_EA_AUTOIDX_EN
    assign ptr_wb_o    = wb_q;
    assign ptr_wb_en_o = (state_q == DONE) && (mode_q == EA_MODE_AUTO);
`else
    assign ptr_wb_o    = 16'h0000;
    assign ptr_wb_en_o = 1'b0;
`endif

endmodule

// File: tb/tb_scmp_ea_seq.sv
// Directed testbench for scmp_ea_seq with a behavioural ALU alongside it.
// Expected values are hand-computed; auto-index expectations follow SCMP_EA_AUTOIDX_EN.
module tb_scmp_ea_seq;
    import scmp_microcode_pak::*;

`ifdef SCMP_EA_AUTOIDX_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    EA_MODE_t    mode;
    logic [15:0] ptr;
    logic [7:0]  disp;
    logic [7:0]  e;
    ALU_OP_t     alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cy;
    logic        alu_hcy_sup;
    logic [7:0]  alu_res;
    logic        alu_cy_out;
    logic        done;
    logic [15:0] ea;
    logic [15:0] ptr_wb;
    logic        ptr_wb_en;

    int compared;
    int mismatched;

    scmp_ea_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .mode_i        (mode),
        .ptr_i         (ptr),
        .disp_i        (disp),
        .e_i           (e),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_cy_o      (alu_cy),
        .alu_hcy_sup_o (alu_hcy_sup),
        .alu_res_i     (alu_res),
        .alu_cy_i      (alu_cy_out),
        .done_o        (done),
        .ea_o          (ea),
        .ptr_wb_o      (ptr_wb),
        .ptr_wb_en_o   (ptr_wb_en)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: only ADD matters to this block.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cy};
        alu_res    = 8'h00;
        alu_cy_out = 1'b0;
        if (alu_op == ALU_OP_ADD) begin
            alu_res    = alu_sum[7:0];
            alu_cy_out = alu_sum[8];
        end
    end

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Run one request from a negedge in IDLE to the negedge after DONE.
    task automatic apply_stimulus(input string tag, input EA_MODE_t m, input logic [15:0] p,
                                  input logic [7:0] d, input logic [7:0] ev,
                                  input logic [7:0] lo_a, input logic [7:0] lo_b,
                                  input logic [7:0] hi_a, input logic [7:0] hi_b, input logic hi_cy,
                                  input logic [15:0] exp_ea, input logic [15:0] exp_wb, input logic exp_en);
        req_valid = 1'b1;
        mode      = m;
        ptr       = p;
        disp      = d;
        e         = ev;
        check_output({tag, " ready_idle"}, {15'd0, req_ready}, 16'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_output({tag, " lo_op"}, {12'd0, alu_op}, {12'd0, ALU_OP_ADD});
        check_output({tag, " lo_a"}, {8'd0, alu_a}, {8'd0, lo_a});
        check_output({tag, " lo_b"}, {8'd0, alu_b}, {8'd0, lo_b});
        check_output({tag, " lo_cy"}, {15'd0, alu_cy}, 16'd0);
        check_output({tag, " lo_ready"}, {15'd0, req_ready}, 16'd0);
        @(negedge clk);
        check_output({tag, " hi_a"}, {8'd0, alu_a}, {8'd0, hi_a});
        check_output({tag, " hi_b"}, {8'd0, alu_b}, {8'd0, hi_b});
        check_output({tag, " hi_cy"}, {15'd0, alu_cy}, {15'd0, hi_cy});
        check_output({tag, " hi_done"}, {15'd0, done}, 16'd0);
        @(negedge clk);
        check_output({tag, " done"}, {15'd0, done}, 16'd1);
        check_output({tag, " done_ready"}, {15'd0, req_ready}, 16'd0);
        check_output({tag, " done_op"}, {12'd0, alu_op}, {12'd0, ALU_OP_NUL});
        check_output({tag, " ea"}, ea, exp_ea);
        check_output({tag, " wb_en"}, {15'd0, ptr_wb_en}, {15'd0, exp_en});
        if (exp_en || !AUTO_ON) begin
            check_output({tag, " ptr_wb"}, ptr_wb, exp_wb);
        end
        @(negedge clk);
        check_output({tag, " done_clr"}, {15'd0, done}, 16'd0);
        check_output({tag, " wb_en_clr"}, {15'd0, ptr_wb_en}, 16'd0);
        check_output({tag, " ea_hold"}, ea, exp_ea);
    endtask

    initial begin
        logic [7:0] ready_seen;
        logic [7:0] done_seen;
        logic       any_done;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        mode       = EA_MODE_IDX;
        ptr        = 16'h0000;
        disp       = 8'h00;
        e          = 8'h00;

        #2;
        check_output("rst ready", {15'd0, req_ready}, 16'd1);
        check_output("rst done", {15'd0, done}, 16'd0);
        check_output("rst ea", ea, 16'h0000);
        check_output("rst wb", ptr_wb, 16'h0000);
        check_output("rst wb_en", {15'd0, ptr_wb_en}, 16'd0);
        check_output("rst op", {12'd0, alu_op}, {12'd0, ALU_OP_NUL});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus("idx", EA_MODE_IDX, 16'h1234, 8'h10, 8'h00,
                       8'h34, 8'h10, 8'h12, 8'h00, 1'b0, 16'h1244, 16'h0000, 1'b0);
        apply_stimulus("wrap_up", EA_MODE_IDX, 16'h1FF0, 8'h20, 8'h00,
                       8'hF0, 8'h20, 8'h1F, 8'h00, 1'b1, 16'h1010, 16'h0000, 1'b0);
        apply_stimulus("wrap_dn", EA_MODE_IDX, 16'h2005, 8'hF0, 8'h00,
                       8'h05, 8'hF0, 8'h20, 8'hFF, 1'b0, 16'h2FF5, 16'h0000, 1'b0);
        apply_stimulus("esub", EA_MODE_IDX, 16'h3000, 8'h80, 8'h05,
                       8'h00, 8'h05, 8'h30, 8'h00, 1'b0, 16'h3005, 16'h0000, 1'b0);
        apply_stimulus("esub80", EA_MODE_IDX, 16'h3000, 8'h80, 8'h80,
                       8'h00, 8'h80, 8'h30, 8'hFF, 1'b0, 16'h3F80, 16'h0000, 1'b0);
        apply_stimulus("zero", EA_MODE_IDX, 16'h5678, 8'h00, 8'h33,
                       8'h78, 8'h00, 8'h56, 8'h00, 1'b0, 16'h5678, 16'h0000, 1'b0);
        apply_stimulus("pre_dec", EA_MODE_AUTO, 16'h4010, 8'hFF, 8'h00,
                       8'h10, 8'hFF, 8'h40, 8'hFF, 1'b1, 16'h400F,
                       AUTO_ON ? 16'h400F : 16'h0000, AUTO_ON);
        apply_stimulus("post_inc", EA_MODE_AUTO, 16'h4010, 8'h01, 8'h00,
                       8'h10, 8'h01, 8'h40, 8'h00, 1'b0,
                       AUTO_ON ? 16'h4010 : 16'h4011,
                       AUTO_ON ? 16'h4011 : 16'h0000, AUTO_ON);

        // Back-to-back: request held high is accepted every fourth cycle.
        req_valid = 1'b1;
        mode      = EA_MODE_IDX;
        ptr       = 16'h0100;
        disp      = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ready_seen[7 - i] = req_ready;
            done_seen[7 - i]  = done;
        end
        req_valid = 1'b0;
        check_output("b2b ready", {8'd0, ready_seen}, 16'h0011);
        check_output("b2b done", {8'd0, done_seen}, 16'h0022);
        check_output("b2b ea", ea, 16'h0101);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset during HI abandons the request.
        req_valid = 1'b1;
        ptr       = 16'h7777;
        disp      = 8'h11;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_output("mid hi_a", {8'd0, alu_a}, 16'h0077);
        rst_n = 1'b0;
        #1;
        check_output("mid ready", {15'd0, req_ready}, 16'd1);
        check_output("mid done", {15'd0, done}, 16'd0);
        check_output("mid ea", ea, 16'h0000);
        check_output("mid wb", ptr_wb, 16'h0000);
        check_output("mid wb_en", {15'd0, ptr_wb_en}, 16'd0);
        check_output("mid op", {12'd0, alu_op}, {12'd0, ALU_OP_NUL});
        check_output("mid a", {8'd0, alu_a}, 16'h0000);
        check_output("mid b", {8'd0, alu_b}, 16'h0000);
        @(negedge clk);
        rst_n    = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        check_output("mid no_done", {15'd0, any_done}, 16'd0);

        apply_stimulus("after_rst", EA_MODE_IDX, 16'h1234, 8'h10, 8'h00,
                       8'h34, 8'h10, 8'h12, 8'h00, 1'b0, 16'h1244, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/scmp_ea_seq.md
Name: scmp_ea_seq

Overview:
Effective-address sequencer that sits directly upstream of the 8-bit ALU and consumes its results. It drives the ALU over two cycles to form the 16-bit memory address ptr + signed displacement, with SC/MP 4K-page wrap and E-register substitution. It also produces the pointer write-back value for auto-indexed addressing. Requests come from the microcode controller; the address goes to the bus interface, and the write-back goes to the pointer register file.

Parameters:
None. Widths are fixed by the architecture: 16-bit address, 8-bit datapath.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  EA request
req_ready_o  out  1  block can accept a request
mode_i  in  EA_MODE_t  EA_MODE_IDX or EA_MODE_AUTO
ptr_i  in  16  base pointer (PC or P1-P3)
disp_i  in  8  instruction displacement
e_i  in  8  E register
alu_op_o  out  ALU_OP_t  ALU operation
alu_a_o  out  8  ALU A operand
alu_b_o  out  8  ALU B operand
alu_cy_o  out  1  ALU carry in
alu_hcy_sup_o  out  1  ALU half-carry suppress
alu_res_i  in  8  ALU result
alu_cy_i  in  1  ALU carry out
done_o  out  1  one-cycle pulse: ea_o and ptr_wb_o are valid
ea_o  out  16  effective address
ptr_wb_o  out  16  pointer write-back value
ptr_wb_en_o  out  1  qualifies ptr_wb_o; valid only with done_o

Behaviour:
- Clock is clk; reset rst_n is asynchronous, active-low.
- Reset forces state IDLE and drives all outputs to 0, except req_ready_o, which is 1. Reset mid-operation abandons the request; no done_o is produced.
- FSM states: IDLE, LO, HI, DONE.
- IDLE: req_ready_o = 1. When req_valid_i = 1:
  - latch ptr_i and mode_i;
  - latch disp_eff = e_i if disp_i == 8'h80, otherwise disp_i;
  - go to LO.
- LO:
  - alu_op_o = ALU_OP_ADD, A = ptr[7:0], B = disp_eff, alu_cy_o = 0, alu_hcy_sup_o = 0;
  - register lo = alu_res_i and c = alu_cy_i;
  - go to HI.
- HI:
  - alu_op_o = ALU_OP_ADD, A = ptr[15:8], B = {8{disp_eff[7]}}, alu_cy_o = c, alu_hcy_sup_o = 0;
  - register sum = {ptr[15:12], alu_res_i[3:0], lo}. The page nibble is always preserved (12-bit wrap), and alu_cy_i is ignored;
  - go to DONE.
- DONE: done_o = 1 for exactly one cycle and req_ready_o = 0; then go to IDLE.
- In IDLE and DONE, alu_op_o = ALU_OP_NUL, A = B = 0, and alu_cy_o = 0.
- Latency: request accepted at edge N, done_o high in cycle N+3. Maximum throughput is one request per 4 cycles.
- Output values in mode IDX: ea_o = sum, ptr_wb_en_o = 0.
- Output values in mode AUTO, negative displacement (disp_eff[7] = 1, pre-decrement): ea_o = sum, ptr_wb_o = sum, ptr_wb_en_o = 1.
- Output values in mode AUTO, non-negative displacement (post-increment): ea_o = ptr, ptr_wb_o = sum, ptr_wb_en_o = 1.
- ea_o and ptr_wb_o hold their values until the next done_o. ptr_wb_en_o is 0 outside DONE.
- Corner cases:
  - disp_eff == 0 gives sum = ptr.
  - e_i == 8'h80 under substitution is used as -128; there is no recursion.
  - Wrap within the page in either direction is silent; no flag is produced.
- req_valid_i outside IDLE is ignored; the requester holds the request until it sees req_ready_o.

Optional Feature:
Macro SCMP_EA_AUTOIDX_EN.
- Defined: behaviour as above.
- Undefined: mode_i is treated as EA_MODE_IDX, ptr_wb_en_o is tied to 0, ptr_wb_o is tied to 0, and the auto-index muxing is removed.

Decomposition:
- scmp_microcode_pak gains:
  - EA_MODE_t enum (EA_MODE_IDX, EA_MODE_AUTO);
  - EA_STATE_t enum (IDLE, LO, HI, DONE);
  - constant EA_DISP_USE_E = 8'h80.
- ALU_OP_t is reused from that package.
- No sub-module. The ALU is instantiated at the datapath level alongside this block, not inside it.

Test Plan:
- IDX: ptr 0x1234, disp 0x10 -> ALU sees A 0x34/B 0x10 then A 0x12/B 0x00; done_o in cycle N+3; ea 0x1244, ptr_wb_en 0.
- Page wrap: ptr 0x1FF0, disp 0x20 -> ea 0x1010. ptr 0x2005, disp 0xF0 -> ea 0x2FF5.
- E substitution: ptr 0x3000, disp 0x80, e 0x05 -> ea 0x3005. Same with e 0x80 -> ea 0x3F80.
- AUTO pre-decrement: ptr 0x4010, disp 0xFF -> ea 0x400F, ptr_wb 0x400F, wb_en 1. AUTO post-increment: ptr 0x4010, disp 0x01 -> ea 0x4010, ptr_wb 0x4011.
- Handshake: req_valid held high continuously -> accepts spaced 4 cycles apart; req_ready_o low in LO/HI/DONE.
- Reset: rst_n asserted during HI -> immediately IDLE, all outputs 0, req_ready 1, no done_o. The next request completes normally.
